// File: rtl/btfly_n_pipe.sv
// Pipelined radix-2 butterfly layer: N_POINTS complex lanes paired at distance STRIDE,
// optional divide-by-2 with rounding, saturation to NB_OUTPUT bits and a sticky clip flag.
module btfly_n_pipe #(
    parameter int NB_INPUT  = 8,
    parameter int NB_OUTPUT = 9,
    parameter int N_POINTS  = 8,
    parameter int STRIDE    = 4
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_enable,
    input  logic                          i_valid,
    input  logic                          i_scale,
    input  logic                          i_ovf_clr,
    input  logic [N_POINTS*NB_INPUT-1:0]  i_data_r,
    input  logic [N_POINTS*NB_INPUT-1:0]  i_data_i,
    output logic                          o_valid,
    output logic [N_POINTS*NB_OUTPUT-1:0] o_data_r,
    output logic [N_POINTS*NB_OUTPUT-1:0] o_data_i,
    output logic                          o_ovf
);

    localparam int NB_SUM = NB_INPUT + 2;
    localparam int NB_CMP = (NB_OUTPUT > NB_SUM) ? NB_OUTPUT : NB_SUM;

    if ((N_POINTS < 4) || (N_POINTS > 32) || ((N_POINTS & (N_POINTS - 1)) != 0)) begin : g_bad_points
        $error("btfly_n_pipe: N_POINTS must be a power of 2 in 4..32");
    end
    if ((STRIDE < 1) || (STRIDE > N_POINTS / 2) || ((STRIDE & (STRIDE - 1)) != 0)) begin : g_bad_stride
        $error("btfly_n_pipe: STRIDE must be a power of 2 in 1..N_POINTS/2");
    end
    if (NB_OUTPUT < 2) begin : g_bad_width
        $error("btfly_n_pipe: NB_OUTPUT must be at least 2");
    end

    function automatic logic signed [NB_SUM-1:0] scale_rnd(input logic signed [NB_SUM-1:0] s,
                                                          input logic sc);
        logic signed [NB_SUM-1:0] t;
        t = s + NB_SUM'(1);
        return sc ? (t >>> 1) : s;
    endfunction

    function automatic logic signed [NB_CMP-1:0] sat_hi();
        logic signed [NB_CMP-1:0] v;
        v = '0;
        v[NB_OUTPUT-2:0] = '1;
        return v;
    endfunction

    function automatic logic signed [NB_CMP-1:0] sat_lo();
        logic signed [NB_CMP-1:0] v;
        v = '1;
        v[NB_OUTPUT-2:0] = '0;
        return v;
    endfunction

    function automatic logic clips(input logic signed [NB_SUM-1:0] s);
        logic signed [NB_CMP-1:0] e;
        e = NB_CMP'(s);
        return (e > sat_hi()) || (e < sat_lo());
    endfunction

    function automatic logic signed [NB_OUTPUT-1:0] saturate(input logic signed [NB_SUM-1:0] s);
        logic signed [NB_CMP-1:0] e;
        e = NB_CMP'(s);
        if (e > sat_hi()) begin
            e = sat_hi();
        end else if (e < sat_lo()) begin
            e = sat_lo();
        end
        return NB_OUTPUT'(e);
    endfunction

    // Stage 1: capture input sample set, valid and scale mode
    logic signed [NB_INPUT-1:0] din_r_p1_d [N_POINTS];
    logic signed [NB_INPUT-1:0] din_r_p1_q [N_POINTS];
    logic signed [NB_INPUT-1:0] din_i_p1_d [N_POINTS];
    logic signed [NB_INPUT-1:0] din_i_p1_q [N_POINTS];
    logic                       vld_p1_d, vld_p1_q;
    logic                       scl_p1_d, scl_p1_q;

    always_comb begin
        vld_p1_d = vld_p1_q;
        scl_p1_d = scl_p1_q;
        for (int k = 0; k < N_POINTS; k++) begin
            din_r_p1_d[k] = din_r_p1_q[k];
            din_i_p1_d[k] = din_i_p1_q[k];
        end
        if (i_enable) begin
            vld_p1_d = i_valid;
            scl_p1_d = i_scale;
            for (int k = 0; k < N_POINTS; k++) begin
                din_r_p1_d[k] = i_data_r[k*NB_INPUT +: NB_INPUT];
                din_i_p1_d[k] = i_data_i[k*NB_INPUT +: NB_INPUT];
            end
        end
    end

    // Stage 2: butterfly, rounding, saturation
    logic signed [NB_OUTPUT-1:0] res_r [N_POINTS];
    logic signed [NB_OUTPUT-1:0] res_i [N_POINTS];
    logic [N_POINTS-1:0]         clip_r;
    logic [N_POINTS-1:0]         clip_i;
    logic signed [NB_OUTPUT-1:0] dout_r_p2_d [N_POINTS];
    logic signed [NB_OUTPUT-1:0] dout_r_p2_q [N_POINTS];
    logic signed [NB_OUTPUT-1:0] dout_i_p2_d [N_POINTS];
    logic signed [NB_OUTPUT-1:0] dout_i_p2_q [N_POINTS];
    logic                        vld_p2_d, vld_p2_q;
    logic                        ovf_d, ovf_q;
    logic                        clip_any;

    for (genvar k = 0; k < N_POINTS; k++) begin : g_lane
        logic signed [NB_SUM-1:0] sum_r;
        logic signed [NB_SUM-1:0] sum_i;
        logic signed [NB_SUM-1:0] scl_r;
        logic signed [NB_SUM-1:0] scl_i;

        if (((k / STRIDE) % 2) == 0) begin : g_top
            assign sum_r = NB_SUM'(din_r_p1_q[k]) + NB_SUM'(din_r_p1_q[k+STRIDE]);
            assign sum_i = NB_SUM'(din_i_p1_q[k]) + NB_SUM'(din_i_p1_q[k+STRIDE]);
        end else begin : g_bot
            assign sum_r = NB_SUM'(din_r_p1_q[k-STRIDE]) - NB_SUM'(din_r_p1_q[k]);
            assign sum_i = NB_SUM'(din_i_p1_q[k-STRIDE]) - NB_SUM'(din_i_p1_q[k]);
        end

        assign scl_r     = scale_rnd(sum_r, scl_p1_q);
        assign scl_i     = scale_rnd(sum_i, scl_p1_q);
        assign res_r[k]  = saturate(scl_r);
        assign res_i[k]  = saturate(scl_i);
        assign clip_r[k] = clips(scl_r);
        assign clip_i[k] = clips(scl_i);

        assign o_data_r[k*NB_OUTPUT +: NB_OUTPUT] = dout_r_p2_q[k];
        assign o_data_i[k*NB_OUTPUT +: NB_OUTPUT] = dout_i_p2_q[k];
    end

    assign clip_any = vld_p1_q && ((|clip_r) || (|clip_i));

    always_comb begin
        vld_p2_d = vld_p2_q;
        for (int k = 0; k < N_POINTS; k++) begin
            dout_r_p2_d[k] = dout_r_p2_q[k];
            dout_i_p2_d[k] = dout_i_p2_q[k];
        end
        if (i_enable) begin
            vld_p2_d = vld_p1_q;
            for (int k = 0; k < N_POINTS; k++) begin
                dout_r_p2_d[k] = res_r[k];
                dout_i_p2_d[k] = res_i[k];
            end
        end
        // a clip arriving together with a clear keeps the flag set
        ovf_d = ovf_q;
        if (i_ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (i_enable && clip_any) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            vld_p1_q <= 1'b0;
            scl_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            ovf_q    <= 1'b0;
            for (int k = 0; k < N_POINTS; k++) begin
                din_r_p1_q[k]  <= '0;
                din_i_p1_q[k]  <= '0;
                dout_r_p2_q[k] <= '0;
                dout_i_p2_q[k] <= '0;
            end
        end else begin
            vld_p1_q <= vld_p1_d;
            scl_p1_q <= scl_p1_d;
            vld_p2_q <= vld_p2_d;
            ovf_q    <= ovf_d;
            for (int k = 0; k < N_POINTS; k++) begin
                din_r_p1_q[k]  <= din_r_p1_d[k];
                din_i_p1_q[k]  <= din_i_p1_d[k];
                dout_r_p2_q[k] <= dout_r_p2_d[k];
                dout_i_p2_q[k] <= dout_i_p2_d[k];
            end
        end
    end

    assign o_valid = vld_p2_q;
    assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_btfly_n_pipe.sv
// Bench for btfly_n_pipe: three configurations share one stimulus stream; a scoreboard
// of model results is popped by a monitor whenever a DUT advances with o_valid set.
module tb_btfly_n_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, en, vld, sc, clr;
    logic [127:0] dr, di;
    logic         va, vb, vc, fa, fb, fc;
    logic [71:0]  ar, ai;
    logic [63:0]  br, bi;
    logic [143:0] cr, ci;

    btfly_n_pipe #(.NB_INPUT(8), .NB_OUTPUT(9), .N_POINTS(8), .STRIDE(4)) u_a (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_valid(vld), .i_scale(sc),
        .i_ovf_clr(clr), .i_data_r(dr[63:0]), .i_data_i(di[63:0]),
        .o_valid(va), .o_data_r(ar), .o_data_i(ai), .o_ovf(fa));

    btfly_n_pipe #(.NB_INPUT(8), .NB_OUTPUT(8), .N_POINTS(8), .STRIDE(4)) u_b (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_valid(vld), .i_scale(sc),
        .i_ovf_clr(clr), .i_data_r(dr[63:0]), .i_data_i(di[63:0]),
        .o_valid(vb), .o_data_r(br), .o_data_i(bi), .o_ovf(fb));

    btfly_n_pipe #(.NB_INPUT(8), .NB_OUTPUT(9), .N_POINTS(16), .STRIDE(1)) u_c (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_valid(vld), .i_scale(sc),
        .i_ovf_clr(clr), .i_data_r(dr), .i_data_i(di),
        .o_valid(vc), .o_data_r(cr), .o_data_i(ci), .o_ovf(fc));

    typedef struct packed {
        logic [15:0][15:0] r;
        logic [15:0][15:0] i;
        logic [31:0]       due;
    } exp_t;

    exp_t q0[$], q1[$], q2[$];
    int   xr[16], xi[16];
    int   errors = 0, checks = 0, ecnt = 0;
    bit   adv = 1'b0, rsted = 1'b0;

    logic [562:0] cur, prev;
    assign cur = {va, ar, ai, vb, br, bi, vc, cr, ci};

    function automatic int fdiv2(int v);
        return (v >= 0) ? v / 2 : -((1 - v) / 2);
    endfunction

    function automatic int satv(int v, int nbo);
        int hi, lo;
        hi = (1 << (nbo - 1)) - 1;
        lo = -(1 << (nbo - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    // Reference: top lane k = x[k]+x[k+s], bottom lane = x[k-s]-x[k]; halve rounding up; clamp.
    function automatic exp_t model(int nbo, int n, int s, bit scl, int due);
        exp_t e;
        int yr, yi;
        e = '0;
        e.due = 32'(due);
        for (int k = 0; k < n; k++) begin
            if (((k / s) % 2) == 0) begin
                yr = xr[k] + xr[k+s];
                yi = xi[k] + xi[k+s];
            end else begin
                yr = xr[k-s] - xr[k];
                yi = xi[k-s] - xi[k];
            end
            if (scl) begin
                yr = fdiv2(yr + 1);
                yi = fdiv2(yi + 1);
            end
            e.r[k] = 16'(satv(yr, nbo));
            e.i[k] = 16'(satv(yi, nbo));
        end
        return e;
    endfunction

    function automatic int lane(logic [143:0] b, int w, int k);
        logic [143:0] t;
        int x;
        t = b >> (k * w);
        x = int'(t[15:0]) & ((1 << w) - 1);
        if (x >= (1 << (w - 1))) x -= (1 << w);
        return x;
    endfunction

    task automatic hchk(string nm, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, got, exp);
        end
    endtask

    task automatic mon(int d, logic v, logic [143:0] orr, logic [143:0] oii);
        exp_t e;
        bit   have, bad;
        int   nbo, n, bk, gr, gi;
        nbo  = (d == 1) ? 8 : 9;
        n    = (d == 2) ? 16 : 8;
        have = 1'b0;
        e    = '0;
        if (v) begin
            if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            else if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            else if (d == 2 && q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
            checks++;
            if (!have) begin
                errors++;
                $display("FAIL unexpected_out dut%0d: got o_valid=1, required no pending set", d);
            end else begin
                bad = 1'b0;
                bk  = 0;
                for (int k = 0; k < n; k++) begin
                    gr = lane(orr, nbo, k);
                    gi = lane(oii, nbo, k);
                    if (!bad && (gr != int'($signed(e.r[k])) || gi != int'($signed(e.i[k])))) begin
                        bad = 1'b1;
                        bk  = k;
                    end
                end
                if (bad) begin
                    errors++;
                    $display("FAIL data dut%0d lane%0d: got %0d/%0d, required %0d/%0d", d, bk,
                             lane(orr, nbo, bk), lane(oii, nbo, bk),
                             int'($signed(e.r[bk])), int'($signed(e.i[bk])));
                end
                checks++;
                if (int'(e.due) != ecnt) begin
                    errors++;
                    $display("FAIL latency dut%0d: got enabled cycle %0d, required %0d", d, ecnt,
                             int'(e.due));
                end
            end
        end
    endtask

    always @(posedge clk) begin
        adv   <= en && !rst;
        rsted <= rst;
        if (en && !rst) ecnt <= ecnt + 1;
        if (rst) begin
            q0.delete();
            q1.delete();
            q2.delete();
        end
    end

    always @(negedge clk) begin
        if (!rsted) begin
            if (adv) begin
                mon(0, va, {72'b0, ar}, {72'b0, ai});
                mon(1, vb, {80'b0, br}, {80'b0, bi});
                mon(2, vc, cr, ci);
            end else begin
                checks++;
                if (cur !== prev) begin
                    errors++;
                    $display("FAIL stall_hold: got outputs changed during stall, required held");
                end
            end
        end
        prev = cur;
    end

    task automatic clrx();
        for (int k = 0; k < 16; k++) begin xr[k] = 0; xi[k] = 0; end
    endtask

    task automatic rnd();
        for (int k = 0; k < 16; k++) begin
            xr[k] = int'($urandom_range(255)) - 128;
            xi[k] = int'($urandom_range(255)) - 128;
        end
    endtask

    task automatic cyc(bit v, bit s, bit e_n, bit c, bit rs);
        vld = v; sc = s; en = e_n; clr = c; rst = rs;
        for (int k = 0; k < 16; k++) begin
            dr[k*8 +: 8] = 8'(xr[k]);
            di[k*8 +: 8] = 8'(xi[k]);
        end
        if (v && e_n && !rs) begin
            q0.push_back(model(9, 8, 4, s, ecnt + 2));
            q1.push_back(model(8, 8, 4, s, ecnt + 2));
            q2.push_back(model(9, 16, 1, s, ecnt + 2));
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; vld = 1'b1; sc = 1'b0; clr = 1'b0; dr = '0; di = '0;
        rnd(); cyc(1, 0, 1, 0, 1);
        rnd(); cyc(1, 1, 1, 0, 1);
        hchk("rst_valid", int'({va, vb, vc}), 0);
        hchk("rst_data", int'(|{ar, ai, br, bi, cr, ci}), 0);
        hchk("rst_ovf", int'({fa, fb, fc}), 0);

        clrx();
        xr[0] = 127;  xr[4] = 127;  xr[1] = -128; xr[5] = 127;
        xi[0] = -127; xi[4] = -127; xi[1] = 127;  xi[5] = -128;
        cyc(1, 0, 1, 0, 0);
        hchk("first_valid_early", int'(va), 0);
        clrx(); cyc(0, 0, 1, 0, 0);
        hchk("first_valid_rise", int'(va), 1);
        hchk("add_r0", lane({72'b0, ar}, 9, 0), 254);
        hchk("add_r4", lane({72'b0, ar}, 9, 4), 0);
        hchk("add_r1", lane({72'b0, ar}, 9, 1), -1);
        hchk("add_r5", lane({72'b0, ar}, 9, 5), -255);
        hchk("add_i0", lane({72'b0, ai}, 9, 0), -254);
        hchk("add_i5", lane({72'b0, ai}, 9, 5), 255);
        hchk("sat_r0", lane({80'b0, br}, 8, 0), 127);
        hchk("sat_r5", lane({80'b0, br}, 8, 5), -128);
        hchk("sat_ovf", int'(fb), 1);

        for (int j = 0; j < 5; j++) begin rnd(); cyc(1, 1'($urandom_range(1)), 1, 0, 0); end
        clrx(); cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 0, 0);

        xr[0] = 127; xr[4] = 126; xr[2] = -2; xr[6] = 1; xr[3] = -128; xr[7] = -128;
        cyc(1, 1, 1, 0, 0);
        clrx(); cyc(0, 0, 1, 0, 0);
        hchk("scl_r0", lane({72'b0, ar}, 9, 0), 127);
        hchk("scl_r4", lane({72'b0, ar}, 9, 4), 1);
        hchk("scl_r2", lane({72'b0, ar}, 9, 2), 0);
        hchk("scl_r6", lane({72'b0, ar}, 9, 6), -1);
        hchk("scl_r3", lane({72'b0, ar}, 9, 3), -128);
        hchk("scl_r7", lane({72'b0, ar}, 9, 7), 0);

        cyc(0, 0, 1, 1, 0);
        hchk("ovf_clear", int'(fb), 0);
        xr[0] = 127; xr[4] = 127;
        cyc(1, 0, 1, 0, 0);
        clrx(); cyc(0, 0, 1, 0, 0);
        hchk("ovf_set", int'(fb), 1);
        cyc(1, 0, 1, 1, 0);
        hchk("ovf_clear_clean", int'(fb), 0);
        xr[0] = 127; xr[4] = 127;
        cyc(1, 0, 1, 0, 0);
        clrx(); cyc(0, 0, 1, 1, 0);
        hchk("ovf_set_beats_clear", int'(fb), 1);
        cyc(0, 0, 1, 0, 0);
        hchk("ovf_sticky", int'(fb), 1);

        for (int j = 0; j < 3; j++) begin rnd(); cyc(1, 1'($urandom_range(1)), 1, 0, 0); end
        for (int j = 0; j < 3; j++) begin rnd(); cyc(1, 1'(j), 0, 0, 0); end
        for (int j = 0; j < 3; j++) begin rnd(); cyc(1, 1'($urandom_range(1)), 1, 0, 0); end
        clrx(); cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 0, 0);

        for (int m = 0; m < 8; m++) begin
            xr[2*m] = m; xr[2*m+1] = 1; xi[2*m] = m; xi[2*m+1] = 1;
        end
        cyc(1, 0, 1, 0, 0);
        clrx(); cyc(0, 0, 1, 0, 0);
        for (int m = 0; m < 8; m++) begin
            hchk($sformatf("s1_r%0d", 2*m), lane(cr, 9, 2*m), m + 1);
            hchk($sformatf("s1_r%0d", 2*m+1), lane(cr, 9, 2*m+1), m - 1);
        end
        hchk("s1_i15", lane(ci, 9, 15), 6);

        rnd(); cyc(1, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 1);
        hchk("rst_mid_valid", int'({va, vb, vc}), 0);
        cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 0, 0);
        hchk("rst_mid_flushed", int'({va, vb, vc}), 0);

        for (int j = 0; j < 400; j++) begin
            rnd();
            cyc(($urandom_range(9) < 7), 1'($urandom_range(1)), ($urandom_range(7) != 0),
                ($urandom_range(15) == 0), 0);
        end
        clrx();
        for (int j = 0; j < 4; j++) cyc(0, 0, 1, 0, 0);
        hchk("drain_a", q0.size(), 0);
        hchk("drain_b", q1.size(), 0);
        hchk("drain_c", q2.size(), 0);
        hchk("no_ovf_wide", int'({fa, fc}), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
